// File: rtl/mat_pkg.sv
// Shared definitions for the matrix datapath: dimension, FSM state, index width,
// and the fixed-point shift-and-reduce (clamps when MAT_MUL_SAT_EN is defined).
package mat_pkg;
  localparam int N         = 5;
  localparam int NN        = N * N;
  localparam int IDX_W     = $clog2(NN);
  localparam int RC_W      = $clog2(N);
  localparam int MAX_DW    = 64;
  localparam int MAX_ACC_W = 2 * MAX_DW + 3;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Arithmetic shift by frac, then reduce to dw bits; result is returned in the
  // low dw bits of a MAX_DW-wide word.
  function automatic logic [MAX_DW-1:0] shift_reduce(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          frac,
    input int                          dw
  );
    logic [MAX_DW-1:0] mask;
`ifdef MAT_MUL_SAT_EN
    logic signed [MAX_ACC_W-1:0] sh;
    logic signed [MAX_ACC_W-1:0] one;
    logic signed [MAX_ACC_W-1:0] hi;
`endif
    mask = ~(MAX_DW'(0)) >> (MAX_DW - dw);
`ifdef MAT_MUL_SAT_EN
    one = MAX_ACC_W'(1);
    sh  = acc >>> frac;
    hi  = (one <<< (dw - 1)) - one;
    if (sh > hi)       sh = hi;
    else if (sh < ~hi) sh = ~hi;
    return MAX_DW'(sh) & mask;
`else
    return MAX_DW'(acc >>> frac) & mask;
`endif
  endfunction
endpackage

// File: rtl/mat_mac.sv
// Signed multiply-accumulate: full-width product added into a guard-bit accumulator.
module mat_mac
  import mat_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 2 * DW + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc,
  output logic signed [AW-1:0] sum
);
  logic signed [2*DW-1:0] prod;

  assign prod = a * b;
  assign sum  = acc + AW'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end
endmodule

// File: rtl/mat_mul_seq.sv
// Sequential 5x5 signed matrix multiply C = A x B with streaming load/emit.
// Define MAT_MUL_SAT_EN to clamp out-of-range results instead of wrapping.
module mat_mul_seq
  import mat_pkg::*;
#(
  parameter int DW        = 32,
  parameter int FRAC_BITS = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_data,
  input  logic [DW-1:0] b_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] c_data,
  output logic          out_last,
  output logic          busy
);
  localparam int AW = 2 * DW + 3;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [RC_W-1:0]   r, c, k;
  logic [DW-1:0]     a_bank [NN];
  logic [DW-1:0]     b_bank [NN];
  logic [IDX_W-1:0]  a_idx, b_idx;
  logic signed [AW-1:0] mac_acc, mac_sum;
  logic              at_last;

  assign a_idx   = IDX_W'(r) * IDX_W'(N) + IDX_W'(k);
  assign b_idx   = IDX_W'(k) * IDX_W'(N) + IDX_W'(c);
  assign at_last = (r == RC_W'(N - 1)) && (c == RC_W'(N - 1));
  assign busy    = !((state == ST_LOAD) && (idx == '0));

  // Operand banks hold no reset: they are fully rewritten by every LOAD.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && in_valid) begin
      a_bank[idx] <= a_data;
      b_bank[idx] <= b_data;
    end
  end

  mat_mac #(.DW(DW), .AW(AW)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_MAC),
    .en  (state == ST_MAC),
    .a   (a_bank[a_idx]),
    .b   (b_bank[b_idx]),
    .acc (mac_acc),
    .sum (mac_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      idx       <= '0;
      r         <= '0;
      c         <= '0;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      c_data    <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            idx <= idx + IDX_W'(1);
            if (idx == IDX_W'(NN - 1)) begin
              state    <= ST_MAC;
              in_ready <= 1'b0;
              r        <= '0;
              c        <= '0;
              k        <= '0;
            end
          end
        end
        ST_MAC: begin
          k <= k + RC_W'(1);
          // Last term: mac_sum already includes A[r][4]*B[4][c].
          if (k == RC_W'(N - 1)) begin
            k         <= '0;
            c_data    <= DW'(shift_reduce(MAX_ACC_W'(mac_sum), FRAC_BITS, DW));
            out_valid <= 1'b1;
            out_last  <= at_last;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (at_last) begin
              state    <= ST_LOAD;
              idx      <= '0;
              in_ready <= 1'b1;
              r        <= '0;
              c        <= '0;
            end else begin
              state <= ST_MAC;
              if (c == RC_W'(N - 1)) begin
                c <= '0;
                r <= r + RC_W'(1);
              end else begin
                c <= c + RC_W'(1);
              end
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end
endmodule

// File: doc/mat_mul_seq.md
# mat_mul_seq

Sequential 5x5 signed matrix multiplier, C = A x B, the recomposition side of the matrix inverter. It is used to check an inverse by multiplying the original matrix by its computed inverse and comparing against identity. Both operands stream in row-major with a valid/ready handshake. A single multiply-accumulate unit then computes each result element over five cycles, and results stream out row-major with a valid/ready handshake.

## Interface
Parameters:
- DW, 32: element width, two's-complement signed.
- FRAC_BITS, 0: fractional bits of the fixed-point format, range 0..DW-2. The value 0 means plain integer.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  the a_data/b_data pair is valid.
- in_ready  out  1  the block accepts a pair in this cycle.
- a_data  in  DW  element A[r][c].
- b_data  in  DW  element B[r][c], same (r, c) as a_data.
- out_valid  out  1  c_data holds a result element.
- out_ready  in  1  the downstream consumer takes c_data.
- c_data  out  DW  element C[r][c].
- out_last  out  1  high with out_valid on C[4][4] only.
- busy  out  1  high whenever the block is not in LOAD with zero elements stored.

## Operation
- State machine with three states: LOAD, MAC, EMIT.
- LOAD:
  - in_ready = 1.
  - Each in_valid & in_ready cycle writes the pair to bank index idx = 5r + c, then increments idx.
  - On the 25th accept, go to MAC with r = 0, c = 0, k = 0, acc = 0.
- MAC:
  - One cycle per k, for k = 0..4: acc += A[r][k] * B[k][c].
  - The product is the full 2*DW-bit signed product. The accumulator is 2*DW+3 bits wide, so it cannot overflow.
  - After k = 4, latch the result into c_data and go to EMIT.
- Result formation:
  - Arithmetic shift right of acc by FRAC_BITS, truncating toward negative infinity.
  - Then reduce to DW bits, as described under Configuration.
- EMIT:
  - out_valid = 1. c_data and out_last stay stable until out_ready.
  - On out_valid & out_ready:
    - If (r, c) = (4, 4), go to LOAD with idx = 0.
    - Otherwise advance c (wrapping to 0 and incrementing r) and return to MAC with acc = 0, k = 0.
- in_ready = 0 in MAC and EMIT; in_valid is ignored there.
- Operand banks are overwritten only by the next LOAD. Back-to-back matrices therefore need no clearing.
- Reset values: state LOAD, idx = 0, r = c = k = 0, acc = 0, in_ready = 1, out_valid = 0, out_last = 0, c_data = 0, busy = 0. Reset mid-LOAD discards the partial matrix.

## Timing
- in_ready is a registered function of state. It deasserts in the cycle after the 25th accept.
- First result: out_valid rises 6 cycles after the cycle of the 25th accept (1 entry cycle + 5 MAC cycles).
- Each later result: out_valid rises 6 cycles after the previous out_valid & out_ready cycle.
- With out_ready held high, one full product takes 25 load cycles + 25 x 6 compute/emit cycles = 175 cycles, plus 1 cycle to return to LOAD.
- Backpressure: out_valid stays high indefinitely while out_ready = 0. No data is lost or duplicated.
- out_ready while out_valid = 0 has no effect.
- Reset asserted in any state reaches reset values immediately, without waiting for a clock edge. The first accept is possible on the first clock edge after rst falls.

## Configuration
- MAT_MUL_SAT_EN defined: a shifted result outside [-2^(DW-1), 2^(DW-1)-1] clamps to the nearest bound.
- MAT_MUL_SAT_EN undefined: the low DW bits of the shifted result are taken (wrap-around). No clamping logic is generated.

## Structure
- Shared package mat_pkg holds:
  - the matrix dimension constant N = 5;
  - the state typedef (LOAD, MAC, EMIT);
  - the element index width constant;
  - a function for shift-and-reduce, shared with the inverter's fixed-point path.
- One sub-module, mat_mac: signed multiplier plus accumulator with clear, accumulate-enable, and a result port.

## Test plan
- Identity: A = I, B = {5,3,1,7,9; 6,4,2,8,-8; 7,5,3,10,9; 9,6,4,-9,-5; 8,5,2,11,4}, FRAC_BITS = 0 -> C equals B element for element; out_last only on the 25th output.
- Row x column: A row 0 = {5,3,1,7,9}, B column 0 = {1,2,3,4,5}, all other entries 0 -> C[0][0] = 87, every other element 0.
- Fixed point: FRAC_BITS = 16, A = 1.5*I (0x00018000), B = 2.0*I (0x00020000) -> diagonal of C = 0x00030000, off-diagonal 0.
- Overflow: all elements 0x7FFFFFFF, FRAC_BITS = 0 -> with MAT_MUL_SAT_EN every C = 0x7FFFFFFF; without it, every C = 0x00000005.
- Backpressure: out_ready held 0 for 10 cycles at the third result, then pulsed every other cycle -> 25 outputs in order, none dropped or repeated, c_data stable while stalled.
- Reset mid-operation: rst pulsed after 12 accepts, then a full identity load -> outputs match the second load only; in_ready = 1 during reset.
